// File: rtl/matmul_pkg.sv
// Shared types, size-code limits and index/width helpers for the sequential matrix multiplier.
package matmul_pkg;

  localparam int unsigned SIZE_W   = 3;
  localparam int unsigned SIZE_MIN = 2;
  localparam int unsigned SIZE_MAX = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    MAC   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Accumulator wide enough that an N-term sum of full-width products cannot overflow.
  function automatic int unsigned acc_w(input int unsigned elem_w, input int unsigned max_n);
    return 2 * elem_w + $clog2(max_n);
  endfunction

  // Row-major element slot within the packed matrix bus.
  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned max_n = SIZE_MAX);
    return r * max_n + c;
  endfunction

endpackage

// File: rtl/matrix_mult_seq_if.sv
// Start/busy/done handshake and packed matrix buses of the sequential matrix multiplier.
interface matrix_mult_seq_if #(
  parameter int unsigned BUS_W = 256
);
  logic             start;
  logic [2:0]       size;
  logic [BUS_W-1:0] matriz_a;
  logic [BUS_W-1:0] matriz_b;
  logic [BUS_W-1:0] data_c;
  logic             busy;
  logic             done;
  logic             error;
  logic             overflow;

  modport master (
    output start, size, matriz_a, matriz_b,
    input  data_c, busy, done, error, overflow
  );

  modport slave (
    input  start, size, matriz_a, matriz_b,
    output data_c, busy, done, error, overflow
  );
endinterface

// File: rtl/matmul_mac.sv
// Signed MAC with clear/enable plus the element reducer.
// MATMUL_SAT_EN defined: reduced element saturates; undefined: it wraps to the low bits.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned MAX_N  = SIZE_MAX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [ELEM_W-1:0] i_a,
  input  logic signed [ELEM_W-1:0] i_b,
  output logic        [ELEM_W-1:0] o_elem_c,
  output logic                     o_ovf_c
);

  localparam int unsigned ACC_W  = acc_w(ELEM_W, MAX_N);
  localparam int unsigned PROD_W = 2 * ELEM_W;

  localparam logic [ELEM_W-1:0] E_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] E_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     w_in_range;

  assign w_prod = PROD_W'(i_a) * PROD_W'(i_b);
  assign w_sum  = r_acc + ACC_W'(w_prod);

  // Fits in ELEM_W when every bit from the element sign bit upward agrees.
  assign w_in_range = (w_sum[ACC_W-1:ELEM_W-1] == '0) || (w_sum[ACC_W-1:ELEM_W-1] == '1);

  always_comb begin
    o_ovf_c  = ~w_in_range;
`ifdef MATMUL_SAT_EN
    o_elem_c = w_in_range ? w_sum[ELEM_W-1:0] : (w_sum[ACC_W-1] ? E_MIN : E_MAX);
`else
    o_elem_c = w_sum[ELEM_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential signed NxN matrix multiplier (N = 2..MAX_N), one MAC per cycle.
// Element reduction saturates when MATMUL_SAT_EN is defined, otherwise wraps.
module matrix_mult_seq
  import matmul_pkg::*;
#(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned MAX_N  = SIZE_MAX,
  parameter int unsigned BUS_W  = 256
) (
  input  logic             clk,
  input  logic             rst,
  matrix_mult_seq_if.slave bus
);

  localparam int unsigned BUS_IW = $clog2(BUS_W);

  state_t             r_state;
  logic [BUS_W-1:0]   r_a;
  logic [BUS_W-1:0]   r_b;
  logic [BUS_W-1:0]   r_buf;
  logic [BUS_W-1:0]   r_data_c;
  logic [SIZE_W-1:0]  r_n;
  logic [SIZE_W-1:0]  r_i;
  logic [SIZE_W-1:0]  r_j;
  logic [SIZE_W-1:0]  r_k;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_overflow;

  logic [BUS_IW-1:0]  w_a_base;
  logic [BUS_IW-1:0]  w_b_base;
  logic [BUS_IW-1:0]  w_c_base;
  logic [SIZE_W-1:0]  w_last;
  logic               w_last_k;
  logic               w_last_j;
  logic               w_last_i;
  logic               w_size_ok;
  logic               w_mac_clr;
  logic               w_mac_en;
  logic [ELEM_W-1:0]  w_elem;
  logic               w_elem_ovf;

  assign w_a_base  = BUS_IW'(idx(32'(r_i), 32'(r_k), MAX_N) * ELEM_W);
  assign w_b_base  = BUS_IW'(idx(32'(r_k), 32'(r_j), MAX_N) * ELEM_W);
  assign w_c_base  = BUS_IW'(idx(32'(r_i), 32'(r_j), MAX_N) * ELEM_W);
  assign w_last    = r_n - SIZE_W'(1);
  assign w_last_k  = (r_k == w_last);
  assign w_last_j  = (r_j == w_last);
  assign w_last_i  = (r_i == w_last);
  assign w_size_ok = (r_n >= SIZE_W'(SIZE_MIN)) && (r_n <= SIZE_W'(MAX_N));
  assign w_mac_en  = (r_state == MAC);
  // Accumulator restarts after each finished dot product and whenever not in MAC.
  assign w_mac_clr = (r_state != MAC) || w_last_k;

  matmul_mac #(
    .ELEM_W (ELEM_W),
    .MAX_N  (MAX_N)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_mac_clr),
    .i_en     (w_mac_en),
    .i_a      (r_a[w_a_base +: ELEM_W]),
    .i_b      (r_b[w_b_base +: ELEM_W]),
    .o_elem_c (w_elem),
    .o_ovf_c  (w_elem_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_buf      <= '0;
      r_data_c   <= '0;
      r_n        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a        <= bus.matriz_a;
            r_b        <= bus.matriz_b;
            r_n        <= bus.size;
            r_buf      <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_error    <= 1'b0;
            r_overflow <= 1'b0;
            r_state    <= CHECK;
          end
        end
        CHECK: begin
          r_busy <= 1'b1;
          if (w_size_ok) begin
            r_state <= MAC;
          end else begin
            r_error <= 1'b1;
            r_state <= DONE;
          end
        end
        MAC: begin
          // k innermost; j advances per finished element, i when j wraps.
          if (w_last_k) begin
            r_buf[w_c_base +: ELEM_W] <= w_elem;
            if (w_elem_ovf) r_overflow <= 1'b1;
            r_k <= '0;
            if (w_last_j) begin
              r_j <= '0;
              if (w_last_i) begin
                r_i     <= '0;
                r_state <= DONE;
              end else begin
                r_i <= r_i + SIZE_W'(1);
              end
            end else begin
              r_j <= r_j + SIZE_W'(1);
            end
          end else begin
            r_k <= r_k + SIZE_W'(1);
          end
        end
        DONE: begin
          r_data_c <= r_buf;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data_c   = r_data_c;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.error    = r_error;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Self-checking bench for matrix_mult_seq: directed test-plan cases plus randomized operands vs a reference model.
module tb_matrix_mult_seq;

  localparam int EW   = 8;
  localparam int MN   = 5;
  localparam int BW   = 256;
  localparam int MAXC = 400;
  localparam int NOMID = 1000;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  matrix_mult_seq_if #(.BUS_W(BW)) bus ();

  matrix_mult_seq #(.ELEM_W(EW), .MAX_N(MN), .BUS_W(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int el(input logic [BW-1:0] m, input int r, input int c);
    logic signed [EW-1:0] e;
    e = m[(r*MN+c)*EW +: EW];
    return int'(e);
  endfunction

  function automatic logic [BW-1:0] put(input logic [BW-1:0] m, input int r, input int c, input int v);
    logic [BW-1:0] t;
    t = m;
    t[(r*MN+c)*EW +: EW] = EW'(v);
    return t;
  endfunction

  // Reference: plain integer matrix product, then clamp or wrap each element to 8 bits.
  task automatic model(input int n, input logic [BW-1:0] a, input logic [BW-1:0] b,
                       output logic [BW-1:0] c, output logic ovf);
    int s;
    int v;
    c   = '0;
    ovf = 1'b0;
    for (int r = 0; r < n; r++) begin
      for (int col = 0; col < n; col++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += el(a, r, k) * el(b, k, col);
        v = s;
        if (s > 127 || s < -128) begin
          ovf = 1'b1;
`ifdef MATMUL_SAT_EN
          v = (s > 127) ? 127 : -128;
`endif
        end
        c = put(c, r, col, v);
      end
    end
  endtask

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] m;
    for (int w = 0; w < BW/32; w++) m[w*32 +: 32] = $urandom;
    return m;
  endfunction

  // Drives one start pulse and observes done latency, busy length and result; optional mid-run start.
  task automatic run_op(input logic [2:0] n, input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input int mid_c, input logic [BW-1:0] a2, input logic [BW-1:0] b2,
                        output int done_c, output int busy_n, output int done_n,
                        output logic held, output logic [BW-1:0] res);
    logic [BW-1:0] pre;
    pre    = bus.data_c;
    done_c = -1;
    busy_n = 0;
    done_n = 0;
    held   = 1'b1;
    res    = '0;
    bus.size     = n;
    bus.matriz_a = a;
    bus.matriz_b = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == mid_c + 1) bus.start = 1'b0;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) begin
        done_n++;
        if (done_c < 0) begin done_c = c; res = bus.data_c; end
      end else if (done_c < 0 && bus.data_c !== pre) begin
        held = 1'b0;
      end
      if (c == mid_c) begin
        bus.matriz_a = a2;
        bus.matriz_b = b2;
        bus.start    = 1'b1;
      end
      if (done_c >= 0 && c >= done_c + 3) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0; bus.size = '0; bus.matriz_a = '0; bus.matriz_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.data_c, bus.busy, bus.done, bus.error, bus.overflow} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got data_c=%h busy=%b done=%b err=%b ovf=%b, need all 0",
                         bus.data_c, bus.busy, bus.done, bus.error, bus.overflow);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_2x2();
    logic [BW-1:0] a, b, e, res;
    int dc, bn, dn;
    logic held;
    a = '0; b = '0; e = '0;
    a = put(a,0,0,1); a = put(a,0,1,2); a = put(a,1,0,3); a = put(a,1,1,4);
    b = put(b,0,0,5); b = put(b,0,1,6); b = put(b,1,0,7); b = put(b,1,1,8);
    e = put(e,0,0,19); e = put(e,0,1,22); e = put(e,1,0,43); e = put(e,1,1,50);
    run_op(3'd2, a, b, NOMID, '0, '0, dc, bn, dn, held, res);
    n_tests++; if (dc !== 10) begin n_fail++; $display("FAIL basic_latency: got %0d need 10", dc); end
    n_tests++; if (bn !== 9) begin n_fail++; $display("FAIL basic_busy_len: got %0d need 9", bn); end
    n_tests++; if (res !== e) begin n_fail++; $display("FAIL basic_result: got %h need %h", res, e); end
    n_tests++; if ({bus.error, bus.overflow} !== 2'b00) begin
      n_fail++; $display("FAIL basic_flags: got err=%b ovf=%b need 0 0", bus.error, bus.overflow); end
    n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL basic_hold: data_c changed before done"); end
  endtask

  task automatic test_identity_3x3();
    logic [BW-1:0] a, b, res;
    int dc, bn, dn;
    logic held;
    a = '0; b = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a = put(a, r, c, (r == c) ? 1 : 0);
        b = put(b, r, c, r*3 + c + 1);
      end
    run_op(3'd3, a, b, NOMID, '0, '0, dc, bn, dn, held, res);
    n_tests++; if (dc !== 29) begin n_fail++; $display("FAIL ident_latency: got %0d need 29", dc); end
    n_tests++; if (res !== b) begin n_fail++; $display("FAIL ident_result: got %h need %h", res, b); end
    n_tests++; if (held !== 1'b1) begin n_fail++; $display("FAIL ident_hold: data_c changed before done"); end
  endtask

  task automatic test_invalid_size();
    logic [BW-1:0] res, a, b, e;
    logic eo;
    int dc, bn, dn;
    logic held;
    logic [2:0] bad [2];
    bad[0] = 3'd7; bad[1] = 3'd0;
    for (int t = 0; t < 2; t++) begin
      run_op(bad[t], rand_bus(), rand_bus(), NOMID, '0, '0, dc, bn, dn, held, res);
      n_tests++; if (dc !== 2) begin n_fail++; $display("FAIL inv_latency size=%0d: got %0d need 2", bad[t], dc); end
      n_tests++; if (bus.error !== 1'b1) begin n_fail++; $display("FAIL inv_error size=%0d: got %b need 1", bad[t], bus.error); end
      n_tests++; if (res !== '0) begin n_fail++; $display("FAIL inv_data size=%0d: got %h need 0", bad[t], res); end
    end
    a = rand_bus(); b = rand_bus();
    model(4, a, b, e, eo);
    run_op(3'd4, a, b, NOMID, '0, '0, dc, bn, dn, held, res);
    n_tests++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL inv_error_clear: got %b need 0", bus.error); end
    n_tests++; if (res !== e) begin n_fail++; $display("FAIL inv_next_result: got %h need %h", res, e); end
    n_tests++; if (dc !== 66) begin n_fail++; $display("FAIL inv_next_latency: got %0d need 66", dc); end
  endtask

  task automatic test_overflow();
    logic [BW-1:0] a, b, e, res;
    int dc, bn, dn;
    logic held;
    int av [2];
    int ev [2];
    av[0] = 127; av[1] = -128;
`ifdef MATMUL_SAT_EN
    ev[0] = 127; ev[1] = -128;
`else
    ev[0] = 2;   ev[1] = 0;
`endif
    for (int t = 0; t < 2; t++) begin
      a = '0; b = '0; e = '0;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          a = put(a, r, c, av[t]); b = put(b, r, c, 127); e = put(e, r, c, ev[t]);
        end
      run_op(3'd2, a, b, NOMID, '0, '0, dc, bn, dn, held, res);
      n_tests++; if (res !== e) begin n_fail++; $display("FAIL ovf_result a=%0d: got %h need %h", av[t], res, e); end
      n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag a=%0d: got %b need 1", av[t], bus.overflow); end
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] a, b, e, res;
    logic eo;
    int dc, bn, dn;
    logic held;
    a = rand_bus(); b = rand_bus();
    model(3, a, b, e, eo);
    run_op(3'd3, a, b, 10, rand_bus(), rand_bus(), dc, bn, dn, held, res);
    n_tests++; if (dn !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d need 1", dn); end
    n_tests++; if (dc !== 29) begin n_fail++; $display("FAIL b2b_latency: got %0d need 29", dc); end
    n_tests++; if (res !== e) begin n_fail++; $display("FAIL b2b_result: got %h need %h", res, e); end
    repeat (5) @(posedge clk);
    #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_not_queued: busy=%b need 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] a, b, e, res;
    logic eo;
    int dc, bn, dn;
    logic held;
    bus.size = 3'd5; bus.matriz_a = rand_bus(); bus.matriz_b = rand_bus();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.data_c, bus.busy, bus.done, bus.error, bus.overflow} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got data_c=%h busy=%b done=%b err=%b ovf=%b, need all 0",
                         bus.data_c, bus.busy, bus.done, bus.error, bus.overflow);
    end
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst = 1'b1;
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
    end
    n_tests++; if (dn !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d busy/done cycles need 0", dn); end
    a = rand_bus(); b = rand_bus();
    model(5, a, b, e, eo);
    run_op(3'd5, a, b, NOMID, '0, '0, dc, bn, dn, held, res);
    n_tests++; if (dc !== 127) begin n_fail++; $display("FAIL rstmid_latency: got %0d need 127", dc); end
    n_tests++; if (res !== e) begin n_fail++; $display("FAIL rstmid_result: got %h need %h", res, e); end
    n_tests++; if (bus.overflow !== eo) begin n_fail++; $display("FAIL rstmid_ovf: got %b need %b", bus.overflow, eo); end
  endtask

  task automatic test_random();
    logic [BW-1:0] a, b, e, res;
    logic eo;
    int dc, bn, dn, n;
    logic held;
    for (int it = 0; it < 16; it++) begin
      n = int'($urandom_range(2, 5));
      a = rand_bus(); b = rand_bus();
      // Small operands on some runs so non-overflow cases are exercised too.
      if (it % 2 == 0)
        for (int r = 0; r < MN; r++)
          for (int c = 0; c < MN; c++) begin
            a = put(a, r, c, int'($urandom_range(0, 8)) - 4);
            b = put(b, r, c, int'($urandom_range(0, 8)) - 4);
          end
      model(n, a, b, e, eo);
      run_op(3'(n), a, b, NOMID, '0, '0, dc, bn, dn, held, res);
      n_tests++; if (res !== e) begin n_fail++; $display("FAIL rand_result it=%0d n=%0d: got %h need %h", it, n, res, e); end
      n_tests++; if (bus.overflow !== eo) begin n_fail++; $display("FAIL rand_ovf it=%0d n=%0d: got %b need %b", it, n, bus.overflow, eo); end
      n_tests++; if (dc !== 2 + n*n*n) begin n_fail++; $display("FAIL rand_latency it=%0d n=%0d: got %0d need %0d", it, n, dc, 2 + n*n*n); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic_2x2();
    test_identity_3x3();
    test_invalid_size();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
